// File: rtl/movement_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | movement_sequencer                                                       |
// | Frame-level sequencer: clear / move / redraw for crosshair, then bird.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module movement_sequencer #(
  parameter int DONE_TIMEOUT = 511,
  parameter int TIMEOUT_W    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       p_left,
  input  logic       p_right,
  input  logic       p_up,
  input  logic       p_down,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_up,
  input  logic       b_down,
  input  logic       bird_en,
  input  logic       done,
  output logic [3:0] control,
  output logic       PorB,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err,
  output logic [7:0] overrun_cnt
);

  typedef enum logic [3:0] {
    HOLD    = 4'b0000,
    PREHOLD = 4'b0100,
    CLEAR   = 4'b0001,
    LEFT    = 4'b0011,
    RIGHT   = 4'b0010,
    DOWN    = 4'b0110,
    UP      = 4'b0111,
    DRAW    = 4'b0101
  } state_t;

  localparam logic [TIMEOUT_W-1:0] c_last_wait = TIMEOUT_W'(DONE_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_porb;
  logic                 w_porb_next;
  logic [3:0]           r_p_req;   // {left, right, up, down}
  logic [3:0]           r_b_req;
  logic                 r_bird_en;
  logic                 r_frame_done;
  logic                 r_timeout_err;
  logic [7:0]           r_overrun;
  logic [TIMEOUT_W-1:0] r_wait_cnt;

  logic [3:0]           w_req;
  logic                 w_go_left;
  logic                 w_go_right;
  logic                 w_go_up;
  logic                 w_go_down;
  logic                 w_done_ok;
  logic                 w_expired;
  logic                 w_timeout;

  always_comb begin
    w_req       = r_porb ? r_b_req : r_p_req;
    w_go_left   = w_req[3] & ~w_req[2];
    w_go_right  = w_req[2] & ~w_req[3];
    w_go_up     = w_req[1] & ~w_req[0];
    w_go_down   = w_req[0] & ~w_req[1];
    // enable is stale from the previous phase during the entry cycle
    w_done_ok   = done & (r_wait_cnt != '0);
    w_expired   = ~w_done_ok & (r_wait_cnt == c_last_wait);
    w_next      = r_state;
    w_porb_next = r_porb;
    w_timeout   = 1'b0;
    case (r_state)
      HOLD:    if (frame_tick) w_next = PREHOLD;
      PREHOLD: w_next = CLEAR;
      CLEAR: begin
        if (w_done_ok | w_expired) begin
          w_timeout = w_expired;
          if (w_go_left)       w_next = LEFT;
          else if (w_go_right) w_next = RIGHT;
          else if (w_go_up)    w_next = UP;
          else if (w_go_down)  w_next = DOWN;
          else                 w_next = DRAW;
        end
      end
      LEFT, RIGHT: begin
        if (w_go_up)        w_next = UP;
        else if (w_go_down) w_next = DOWN;
        else                w_next = DRAW;
      end
      UP, DOWN: w_next = DRAW;
      DRAW: begin
        if (w_done_ok | w_expired) begin
          w_timeout = w_expired;
          if (!r_porb && r_bird_en) begin
            w_next      = CLEAR;
            w_porb_next = 1'b1;
          end else begin
            w_next      = HOLD;
            w_porb_next = 1'b0;
          end
        end
      end
      default: begin
        w_next      = HOLD;
        w_porb_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= HOLD;
      r_porb        <= 1'b0;
      r_p_req       <= '0;
      r_b_req       <= '0;
      r_bird_en     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_porb       <= w_porb_next;
      r_frame_done <= (r_state == DRAW) && (w_next == HOLD);
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (r_state == CLEAR || r_state == DRAW)
        r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      if (frame_tick && r_state != HOLD && r_overrun != 8'hFF)
        r_overrun <= r_overrun + 8'd1;
      // requests are frozen for the whole pass
      if (frame_tick && r_state == HOLD) begin
        r_p_req   <= {p_left, p_right, p_up, p_down};
        r_b_req   <= {b_left, b_right, b_up, b_down};
        r_bird_en <= bird_en;
      end
    end
  end

  assign control     = r_state;
  assign PorB        = r_porb;
  assign busy        = (r_state != HOLD);
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign overrun_cnt = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_movement_sequencer.sv
`default_nettype none
// Bench for movement_sequencer: phase-list reference model plus directed literal checks.
module tb_movement_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic p_left = 1'b0, p_right = 1'b0, p_up = 1'b0, p_down = 1'b0;
  logic b_left = 1'b0, b_right = 1'b0, b_up = 1'b0, b_down = 1'b0;
  logic bird_en = 1'b0;
  logic done = 1'b0;
  logic [3:0] control;
  logic PorB, busy, frame_done, timeout_err;
  logic [7:0] overrun_cnt;

  movement_sequencer #(.DONE_TIMEOUT(511), .TIMEOUT_W(9)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .p_left(p_left), .p_right(p_right), .p_up(p_up), .p_down(p_down),
    .b_left(b_left), .b_right(b_right), .b_up(b_up), .b_down(b_down),
    .bird_en(bird_en), .done(done), .control(control), .PorB(PorB),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a pass is a list of phases; the head is what the DUT shows.
  typedef struct packed {logic [3:0] code; logic porb; logic wt;} phase_t;
  phase_t q[$];
  int   m_cnt;
  logic m_fd, m_to;
  int   m_ovr;

  task automatic m_reset();
    q.delete(); m_cnt = 0; m_fd = 0; m_to = 0; m_ovr = 0;
  endtask

  task automatic push_obj(input logic porb, input logic l, r, u, d);
    q.push_back(phase_t'({4'b0001, porb, 1'b1}));
    if (l && !r)      q.push_back(phase_t'({4'b0011, porb, 1'b0}));
    else if (r && !l) q.push_back(phase_t'({4'b0010, porb, 1'b0}));
    if (u && !d)      q.push_back(phase_t'({4'b0111, porb, 1'b0}));
    else if (d && !u) q.push_back(phase_t'({4'b0110, porb, 1'b0}));
    q.push_back(phase_t'({4'b0101, porb, 1'b1}));
  endtask

  task automatic model_step();
    logic adv;
    logic fd;
    fd = 1'b0;
    if (q.size() == 0) begin
      if (frame_tick) begin
        q.push_back(phase_t'({4'b0100, 1'b0, 1'b0}));
        push_obj(1'b0, p_left, p_right, p_up, p_down);
        if (bird_en) push_obj(1'b1, b_left, b_right, b_up, b_down);
        m_cnt = 0;
      end
    end else begin
      if (frame_tick && m_ovr < 255) m_ovr++;
      adv = 1'b1;
      if (q[0].wt) begin
        if (m_cnt >= 1 && done) adv = 1'b1;
        else if (m_cnt + 1 == 511) begin adv = 1'b1; m_to = 1'b1; end
        else adv = 1'b0;
      end
      if (adv) begin
        void'(q.pop_front());
        m_cnt = 0;
        if (q.size() == 0) fd = 1'b1;
      end else m_cnt++;
    end
    m_fd = fd;
  endtask

  function automatic int exp_vec();
    logic       b;
    logic [3:0] c;
    logic       p;
    b = (q.size() != 0);
    c = b ? q[0].code : 4'b0000;
    p = b ? q[0].porb : 1'b0;
    return int'({c, p, b, m_fd, m_to, m_ovr[7:0]});
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk); #1;
      if (reset) m_reset(); else model_step();
      chk("cycle_outputs", int'({control, PorB, busy, frame_done, timeout_err, overrun_cnt}), exp_vec());
    end
  end

  logic [4:0] trq[$];
  logic scramble = 1'b0;

  task automatic run_traced();
    trq.delete();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      trq.push_back({PorB, control});
      @(negedge clk);
      frame_tick = 1'b0;
      if (scramble) begin
        {p_left, p_right, p_up, p_down} = 4'($urandom);
        {b_left, b_right, b_up, b_down} = 4'($urandom);
        bird_en = 1'($urandom);
      end
      if (frame_done) return;
    end
    chk("pass_bound", int'(frame_done), 1);
  endtask

  task automatic check_trace(input string nm, input logic [4:0] e[$]);
    chk({nm, "_len"}, trq.size(), e.size());
    for (int i = 0; i < e.size() && i < trq.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), int'(trq[i]), int'(e[i]));
  endtask

  task automatic wait_ctrl(input logic [4:0] want, input string nm);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if ({PorB, control} == want) return;
    end
    chk(nm, int'({PorB, control}), int'(want));
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #2;
      if (!busy) return;
    end
    chk(nm, int'(busy), 0);
  endtask

  initial begin
    logic [4:0] e[$];
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("reset_state", int'({control, PorB, busy, frame_done, timeout_err, overrun_cnt}), 0);

    // minimum pass: player only, no moves
    @(negedge clk);
    done = 1'b1; frame_tick = 1'b1;
    run_traced();
    e = '{5'h04, 5'h01, 5'h01, 5'h05, 5'h05, 5'h00};
    check_trace("min_pass", e);

    // player LEFT then bird UP
    @(negedge clk);
    p_left = 1'b1; b_up = 1'b1; bird_en = 1'b1; frame_tick = 1'b1;
    run_traced();
    e = '{5'h04, 5'h01, 5'h01, 5'h03, 5'h05, 5'h05,
          5'h11, 5'h11, 5'h17, 5'h15, 5'h15, 5'h00};
    check_trace("bird_pass", e);

    // left+right cancel, inputs scrambled after the tick
    @(negedge clk);
    p_left = 1'b1; p_right = 1'b1; p_up = 1'b1; p_down = 1'b0;
    b_up = 1'b0; bird_en = 1'b0; frame_tick = 1'b1;
    scramble = 1'b1;
    run_traced();
    scramble = 1'b0;
    e = '{5'h04, 5'h01, 5'h01, 5'h07, 5'h05, 5'h05, 5'h00};
    check_trace("cancel_pass", e);

    // timeout: done high on CLEAR entry, low afterwards
    @(negedge clk);
    {p_left, p_right, p_up, p_down} = 4'b0000;
    {b_left, b_right, b_up, b_down} = 4'b0000;
    bird_en = 1'b0; done = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_ctrl(5'h01, "reach_clear");
    n = 1;
    @(negedge clk);
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #2;
      if (control != 4'b0001) break;
      n++;
      @(negedge clk);
      done = 1'b0;
    end
    chk("timeout_clear_cycles", n, 511);
    chk("timeout_err_set", int'(timeout_err), 1);
    @(negedge clk);
    done = 1'b1;
    wait_idle("timeout_idle");
    chk("timeout_err_sticky", int'(timeout_err), 1);

    // overruns during a long bird CLEAR
    @(negedge clk);
    bird_en = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_ctrl(5'h11, "reach_bird_clear");
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      frame_tick = (i == 20 || i == 60 || i == 100);
    end
    frame_tick = 1'b0;
    done = 1'b1;
    wait_ctrl(5'h15, "reach_bird_draw");
    @(negedge clk);
    done = 1'b0;
    chk("overrun_three", int'(overrun_cnt), 3);

    // async reset mid bird DRAW
    repeat (5) @(negedge clk);
    chk("pre_reset_porb", int'(PorB), 1);
    reset = 1'b1;
    #1;
    chk("async_reset", int'({control, PorB, busy, frame_done, timeout_err, overrun_cnt}), 0);
    @(posedge clk); #2;
    chk("reset_next_cycle", int'({control, PorB, busy, overrun_cnt, timeout_err}), 0);
    @(negedge clk);
    reset = 1'b0;

    // overrun saturation
    @(negedge clk);
    bird_en = 1'b0; done = 1'b0; frame_tick = 1'b1;
    repeat (261) @(negedge clk);
    frame_tick = 1'b0;
    chk("overrun_saturate", int'(overrun_cnt), 255);
    done = 1'b1;
    wait_idle("sat_idle");

    // randomized traffic
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 9) == 0);
      done = ($urandom_range(0, 2) != 0);
      {p_left, p_right, p_up, p_down} = 4'($urandom);
      {b_left, b_right, b_up, b_down} = 4'($urandom);
      bird_en = 1'($urandom);
    end
    @(negedge clk);
    frame_tick = 1'b0; done = 1'b1;
    wait_idle("final_idle");
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/movement_sequencer.md
Name: movement_sequencer

Overview:
- Frame-level controller for the crosshair/bird movement datapath.
- On each frame tick it runs a fixed pass over the player crosshair, then the bird. Each object gets: clear, requested move steps, redraw.
- Drives the datapath's 4-bit control code and PorB select, and waits on the datapath's done (enable) handshake.
- Sits between the input/bird-AI logic and the movement datapath.

Parameters:
DONE_TIMEOUT, 511, max cycles to wait for done in a CLEAR/DRAW phase before forcing advance
TIMEOUT_W, 9, width of wait counter; must hold DONE_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse requesting a frame pass
p_left, p_right, p_up, p_down  in  1 each  crosshair move requests (level)
b_left, b_right, b_up, b_down  in  1 each  bird move requests (level)
bird_en  in  1  bird on screen; 0 skips all bird phases
done  in  1  datapath completion (its enable output)
control  out  4  datapath control code
PorB  out  1  0 = player crosshair, 1 = bird
busy  out  1  high whenever state != HOLD
frame_done  out  1  one-cycle pulse on return to HOLD
timeout_err  out  1  sticky; a done wait timed out
overrun_cnt  out  8  saturating count of frame_ticks dropped while busy

Behaviour:
- Control encoding (fixed, shared with datapath): HOLD=0000, PREHOLD=0100, CLEAR=0001, LEFT=0011, RIGHT=0010, DOWN=0110, UP=0111, DRAW=0101.
- control is a registered output equal to the current state's code.
- Reset (async, any time, including mid-pass): state HOLD, control=0000, PorB=0, busy=0, frame_done=0, timeout_err=0, overrun_cnt=0. All latched requests and the wait counter clear to 0.
- HOLD:
  - On frame_tick, latch all eight requests and bird_en, then go to PREHOLD with PorB=0.
  - Latched values are the ones used for the whole pass; later input changes are ignored.
- PREHOLD: one cycle, then CLEAR.
- Per object (player first with PorB=0, then bird with PorB=1), phase order is CLEAR, X step, Y step, DRAW.
- CLEAR and DRAW are wait states:
  - The wait counter clears on entry and increments each cycle.
  - done is ignored in the entry cycle, because datapath enable is stale from the previous phase.
  - From the second cycle on, done=1 advances on the next edge.
  - If the counter reaches DONE_TIMEOUT without a qualifying done, advance anyway and set timeout_err.
- X step: one cycle of LEFT if left&!right, RIGHT if right&!left. Both or neither means no X state is entered.
- Y step: one cycle of UP if up&!down, DOWN if down&!up. Same exclusion rule.
- Move states are single-cycle; the datapath performs the 1-pixel step.
- PorB changes only on the edge from player DRAW to bird CLEAR, and back to 0 on return to HOLD. It is never toggled mid-phase.
- After player DRAW:
  - If latched bird_en=1, go to bird CLEAR.
  - Otherwise go to HOLD.
- After bird DRAW, go to HOLD.
- frame_done is asserted in the first HOLD cycle after a pass.
- A frame_tick in that same cycle starts a new pass and is not counted as an overrun.
- A frame_tick while busy is dropped and overrun_cnt increments, saturating at 255.
- Minimum pass, player only, no moves, done immediate on second cycle: PREHOLD 1, CLEAR 2, DRAW 2, then HOLD. Tick at cycle 0 gives frame_done at cycle 6.
- Latency: control becomes PREHOLD on the edge after the tick is sampled.

Test Plan:
- Reset mid-DRAW with PorB=1 → next cycle control=0000, PorB=0, busy=0, overrun_cnt=0, timeout_err=0.
- frame_tick, bird_en=0, no requests, done high on 2nd cycle of each wait → control sequence 0100,0001,0001,0101,0101,0000, with frame_done pulse on the first 0000.
- Tick with p_left=1, b_up=1, bird_en=1 → player: 0001…,0011,0101…; bird (PorB=1): 0001…,0111,0101…; exactly one LEFT cycle and one UP cycle.
- p_left=p_right=1, p_up=1 → no LEFT/RIGHT state; one UP cycle. Changing inputs mid-pass does not alter the sequence.
- done held at 1 entering CLEAR, then held at 0 → entry-cycle done ignored; advance after 511 cycles with timeout_err=1 thereafter.
- Three ticks issued during a bird CLEAR of 150 cycles → overrun_cnt=3; 260 dropped ticks → overrun_cnt=255.
